// File: rtl/pipe_control_unit.sv
// rtl/pipe_control_unit.sv - decode-to-EX pipeline control: opcode decode, EX register,
// memory-wait/timeout, branch flush, load-use interlock and stall counting.
module pipe_control_unit #(
  parameter int ALUOP_W = 3,
  parameter int REG_AW  = 5,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_valid,
  input  logic [5:0]             opcode,
  input  logic [5:0]             func,
  input  logic [REG_AW-1:0]      rs,
  input  logic [REG_AW-1:0]      rt,
  input  logic [REG_AW-1:0]      rd,
  input  logic                   branch_taken,
  input  logic                   mem_ready,
  output logic                   id_ready,
  output logic                   ex_valid,
  output logic [16+ALUOP_W-1:0]  ex_ctrl,
  output logic [REG_AW-1:0]      ex_wreg,
  output logic                   illegal,
  output logic                   mem_timeout,
  output logic [CNT_W-1:0]       stall_cnt
);

  localparam int CTRL_W = 16 + ALUOP_W;
  localparam int WC_W   = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {RUN, MEM_WAIT, FLUSH} state_t;

  state_t state, state_n;
  logic [WC_W-1:0] wait_cnt, wait_n;

  logic [ALUOP_W-1:0] d_aluop;
  logic       d_regwrite, d_alusrc1, d_mem_wr, d_mem_rd, d_word_byte, d_zero_ext, d_illegal;
  logic [1:0] d_regdest, d_alusrc2, d_jump, d_branch, d_regsrc;
  logic [CTRL_W-1:0] dec_ctrl;
  logic [REG_AW-1:0] dec_wreg;

  always_comb begin
    d_aluop     = '0;
    d_regwrite  = 1'b0;
    d_regdest   = 2'b00;
    d_alusrc1   = 1'b1;
    d_alusrc2   = 2'b00;
    d_jump      = 2'b00;
    d_branch    = 2'b00;
    d_regsrc    = 2'b00;
    d_mem_wr    = 1'b0;
    d_mem_rd    = 1'b0;
    d_word_byte = 1'b0;
    d_zero_ext  = 1'b0;
    d_illegal   = 1'b0;
    case (opcode)
      6'h03: begin
        case (func)
          6'h08: d_jump = 2'b10;
          6'h21: begin
            d_regwrite = 1'b1;
            d_mem_rd   = 1'b1;
            d_regsrc   = 2'b01;
          end
          6'h13: d_mem_wr = 1'b1;
          default: begin
            d_regwrite = 1'b1;
            d_regdest  = 2'b01;
          end
        endcase
      end
      6'h02: d_jump = 2'b01;
      6'h07: begin
        d_regwrite = 1'b1;
        d_jump     = 2'b01;
        d_regdest  = 2'b10;
        d_alusrc1  = 1'b0;
        d_alusrc2  = 2'b10;
        d_aluop    = ALUOP_W'(1);
      end
      6'h09, 6'h0c, 6'h0e: begin
        d_regwrite = 1'b1;
        d_alusrc2  = 2'b01;
        d_zero_ext = (opcode != 6'h09);
        d_aluop    = (opcode == 6'h09) ? ALUOP_W'(1) :
                     (opcode == 6'h0c) ? ALUOP_W'(3) : ALUOP_W'(4);
      end
      6'h05, 6'h04: begin
        d_aluop  = ALUOP_W'(2);
        d_branch = (opcode == 6'h05) ? 2'b01 : 2'b10;
      end
      6'h12, 6'h22: begin
        d_aluop     = ALUOP_W'(1);
        d_alusrc2   = 2'b01;
        d_regwrite  = 1'b1;
        d_mem_rd    = 1'b1;
        d_regsrc    = 2'b01;
        d_word_byte = (opcode == 6'h22);
      end
      6'h2b, 6'h28: begin
        d_aluop     = ALUOP_W'(1);
        d_alusrc2   = 2'b01;
        d_mem_wr    = 1'b1;
        d_word_byte = (opcode == 6'h28);
      end
      6'h0f: begin
        d_regwrite = 1'b1;
        d_regsrc   = 2'b10;
      end
      default: d_illegal = 1'b1;
    endcase
  end

  assign dec_ctrl = {d_aluop, d_regwrite, d_regdest, d_alusrc1, d_alusrc2, d_jump,
                     d_branch, d_regsrc, d_mem_wr, d_mem_rd, d_word_byte, d_zero_ext};

  always_comb begin
    case (d_regdest)
      2'b00:   dec_wreg = rt;
      2'b01:   dec_wreg = rd;
      default: dec_wreg = '1;
    endcase
  end

  // Fields of the instruction currently held in EX
  logic       ex_mem_rd, ex_mem_wr;
  logic [1:0] ex_jump, ex_branch;
  logic       mem_hold, br_flush, load_use;

  assign ex_mem_rd = ex_ctrl[2];
  assign ex_mem_wr = ex_ctrl[3];
  assign ex_branch = ex_ctrl[7:6];
  assign ex_jump   = ex_ctrl[9:8];

  assign mem_hold = ex_valid & (ex_mem_rd | ex_mem_wr) & ~mem_ready;
  assign br_flush = ex_valid & branch_taken & ((ex_jump != 2'b00) | (ex_branch != 2'b00));
  assign load_use = ex_valid & ex_mem_rd & (ex_wreg != '0) & ((ex_wreg == rs) | (ex_wreg == rt));

  logic id_ready_c, issue, keep, timeout_hit;

  always_comb begin
    state_n     = state;
    wait_n      = '0;
    id_ready_c  = 1'b0;
    issue       = 1'b0;
    keep        = 1'b0;
    timeout_hit = 1'b0;
    if (mem_hold) begin
      keep = 1'b1;
      if (state == MEM_WAIT) begin
        if (wait_cnt == WC_W'(TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          keep        = 1'b0;
          state_n     = RUN;
        end else begin
          wait_n = wait_cnt + 1'b1;
        end
      end else begin
        state_n = MEM_WAIT;
      end
    end else if (state == FLUSH) begin
      id_ready_c = 1'b1;
      state_n    = RUN;
    end else if (br_flush) begin
      id_ready_c = 1'b1;
      state_n    = FLUSH;
    end else if (load_use) begin
      state_n = RUN;
    end else begin
      state_n    = RUN;
      id_ready_c = id_valid;
      issue      = id_valid;
    end
  end

  assign id_ready = id_ready_c & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      wait_cnt    <= '0;
      ex_valid    <= 1'b0;
      ex_ctrl     <= '0;
      ex_wreg     <= '0;
      illegal     <= 1'b0;
      mem_timeout <= 1'b0;
      stall_cnt   <= '0;
    end else begin
      state    <= state_n;
      wait_cnt <= wait_n;
      illegal  <= issue & d_illegal;
      if (timeout_hit)
        mem_timeout <= 1'b1;
      // Anything not held or legally issued becomes a bubble
      if (!keep) begin
        if (issue && !d_illegal) begin
          ex_valid <= 1'b1;
          ex_ctrl  <= dec_ctrl;
          ex_wreg  <= dec_wreg;
        end else begin
          ex_valid <= 1'b0;
          ex_ctrl  <= '0;
          ex_wreg  <= '0;
        end
      end
      if (id_valid && !id_ready_c && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_control_unit.sv
// tb/tb_pipe_control_unit.sv - scoreboard bench for pipe_control_unit against an
// instruction-level reference model, directed scenarios plus randomized traffic.
module tb_pipe_control_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid = 1'b0;
  logic [5:0]  opcode = '0, func = '0;
  logic [4:0]  rs = '0, rt = '0, rd = '0;
  logic        branch_taken = 1'b0, mem_ready = 1'b1;
  logic        id_ready, ex_valid, illegal, mem_timeout;
  logic [18:0] ex_ctrl;
  logic [4:0]  ex_wreg;
  logic [7:0]  stall_cnt;

  pipe_control_unit #(.ALUOP_W(3), .REG_AW(5), .TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .opcode(opcode), .func(func),
    .rs(rs), .rt(rt), .rd(rd), .branch_taken(branch_taken), .mem_ready(mem_ready),
    .id_ready(id_ready), .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_wreg(ex_wreg),
    .illegal(illegal), .mem_timeout(mem_timeout), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {int cyc; logic rdy; logic v; logic ill; logic to; logic [7:0] st;} st_t;
  typedef struct {int cyc; logic [18:0] ctrl; logic [4:0] wreg;} ex_t;
  st_t st_q[$];
  ex_t ex_q[$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  bit         m_v, m_ill, m_to, m_flush;
  logic [18:0] m_ctrl;
  logic [4:0]  m_wreg;
  int         m_hold, m_stall;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [18:0] pk(input int aluop, rw, rdst, s1, s2, j, b, rsrc, mw, mr, wb, ze);
    return {3'(aluop), 1'(rw), 2'(rdst), 1'(s1), 2'(s2), 2'(j), 2'(b), 2'(rsrc),
            1'(mw), 1'(mr), 1'(wb), 1'(ze)};
  endfunction

  // Returns {illegal, ctrl}
  function automatic logic [19:0] ref_decode(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h03: case (fn)
               6'h08:   return {1'b0, pk(0,0,0,1,0,2,0,0,0,0,0,0)};
               6'h21:   return {1'b0, pk(0,1,0,1,0,0,0,1,0,1,0,0)};
               6'h13:   return {1'b0, pk(0,0,0,1,0,0,0,0,1,0,0,0)};
               default: return {1'b0, pk(0,1,1,1,0,0,0,0,0,0,0,0)};
             endcase
      6'h02: return {1'b0, pk(0,0,0,1,0,1,0,0,0,0,0,0)};
      6'h07: return {1'b0, pk(1,1,2,0,2,1,0,0,0,0,0,0)};
      6'h09: return {1'b0, pk(1,1,0,1,1,0,0,0,0,0,0,0)};
      6'h0c: return {1'b0, pk(3,1,0,1,1,0,0,0,0,0,0,1)};
      6'h0e: return {1'b0, pk(4,1,0,1,1,0,0,0,0,0,0,1)};
      6'h05: return {1'b0, pk(2,0,0,1,0,0,1,0,0,0,0,0)};
      6'h04: return {1'b0, pk(2,0,0,1,0,0,2,0,0,0,0,0)};
      6'h12: return {1'b0, pk(1,1,0,1,1,0,0,1,0,1,0,0)};
      6'h22: return {1'b0, pk(1,1,0,1,1,0,0,1,0,1,1,0)};
      6'h2b: return {1'b0, pk(1,0,0,1,1,0,0,0,1,0,0,0)};
      6'h28: return {1'b0, pk(1,0,0,1,1,0,0,0,1,0,1,0)};
      6'h0f: return {1'b0, pk(0,1,0,1,0,0,0,2,0,0,0,0)};
      default: return {1'b1, 19'd0};
    endcase
  endfunction

  task automatic step(input bit r, input bit iv, input logic [5:0] op, input logic [5:0] fn,
                      input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                      input bit bt, input bit mr);
    logic [19:0] dec;
    bit hold, brf, lu, rdy, take;
    @(posedge clk); #1;
    rst = r; id_valid = iv; opcode = op; func = fn; rs = s; rt = t; rd = d;
    branch_taken = bt; mem_ready = mr;
    cyc++;
    if (r) begin
      m_v = 0; m_ctrl = '0; m_wreg = '0; m_ill = 0; m_to = 0; m_flush = 0; m_hold = 0; m_stall = 0;
    end
    hold = m_v && (m_ctrl[2] || m_ctrl[3]) && !mr;
    brf  = m_v && bt && (m_ctrl[9:8] != 0 || m_ctrl[7:6] != 0);
    lu   = m_v && m_ctrl[2] && m_wreg != 0 && (m_wreg == s || m_wreg == t);
    if (r || hold)           rdy = 0;
    else if (m_flush || brf) rdy = 1;
    else if (lu)             rdy = 0;
    else                     rdy = iv;
    st_q.push_back('{cyc, rdy, m_v, m_ill, m_to, 8'(m_stall)});
    if (m_v) ex_q.push_back('{cyc, m_ctrl, m_wreg});
    if (!r) begin
      if (iv && !rdy && m_stall < 255) m_stall++;
      m_ill = 0;
      if (hold) begin
        m_hold++;
        if (m_hold == TO + 1) begin m_to = 1; m_v = 0; m_hold = 0; end
      end else begin
        m_hold = 0;
        dec  = ref_decode(op, fn);
        take = !m_flush && !brf && !lu && iv;
        if (take && !dec[19]) begin
          m_v = 1; m_ctrl = dec[18:0];
          m_wreg = (dec[14:13] == 2'd0) ? t : (dec[14:13] == 2'd1) ? d : 5'd31;
        end else begin
          m_v = 0; m_ctrl = '0; m_wreg = '0;
          m_ill = take;
        end
        m_flush = !m_flush && brf;
      end
    end
  endtask

  task automatic idle(input bit mr);
    step(0, 0, 6'h00, 6'h00, 0, 0, 0, 0, mr);
  endtask

  // Monitor: status every cycle, EX contents whenever the DUT presents a live instruction
  initial begin
    st_t s;
    ex_t e;
    forever begin
      @(negedge clk);
      if (st_q.size() != 0) begin
        s = st_q.pop_front();
        chk("id_ready", id_ready, s.rdy);
        chk("ex_valid", ex_valid, s.v);
        chk("illegal", illegal, s.ill);
        chk("mem_timeout", mem_timeout, s.to);
        chk("stall_cnt", stall_cnt, s.st);
      end
      if (ex_valid === 1'b1) begin
        if (ex_q.size() == 0) begin
          chk("ex_unexpected", 1, 0);
        end else begin
          e = ex_q.pop_front();
          chk("ex_cycle", cyc, e.cyc);
          chk("ex_ctrl", ex_ctrl, e.ctrl);
          chk("ex_wreg", ex_wreg, e.wreg);
        end
      end
    end
  end

  initial begin
    logic [5:0] ops[16] = '{6'h03, 6'h03, 6'h02, 6'h07, 6'h09, 6'h0c, 6'h0e, 6'h05,
                            6'h04, 6'h12, 6'h22, 6'h2b, 6'h28, 6'h0f, 6'h3f, 6'h01};
    logic [5:0] fns[4] = '{6'h08, 6'h21, 6'h13, 6'h20};
    step(1, 0, 0, 0, 0, 0, 0, 0, 1);
    #1;
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_ex_ctrl", ex_ctrl, 0);
    chk("rst_id_ready", id_ready, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1);

    // addi rt=3
    step(0, 1, 6'h09, 0, 1, 3, 0, 0, 1);
    idle(1); #1;
    chk("addi_valid", ex_valid, 1);
    chk("addi_aluop", ex_ctrl[18:16], 1);
    chk("addi_regwrite", ex_ctrl[15], 1);
    chk("addi_alusrc1", ex_ctrl[12], 1);
    chk("addi_alusrc2", ex_ctrl[11:10], 2'b01);
    chk("addi_wreg", ex_wreg, 3);

    // lw r5 then add using r5
    step(1, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 1, 6'h12, 0, 0, 5, 0, 0, 1);
    step(0, 1, 6'h03, 6'h20, 5, 6, 7, 0, 1); #1;
    chk("lu_stall_ready", id_ready, 0);
    step(0, 1, 6'h03, 6'h20, 5, 6, 7, 0, 1); #1;
    chk("lu_bubble", ex_valid, 0);
    chk("lu_accept", id_ready, 1);
    idle(1); #1;
    chk("lu_add_valid", ex_valid, 1);
    chk("lu_add_wreg", ex_wreg, 7);
    chk("lu_stall_cnt", stall_cnt, 1);

    // sw held three cycles
    step(0, 1, 6'h2b, 0, 1, 2, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 6'h09, 0, 0, 4, 0, 0, 0); #1;
      chk("sw_hold_valid", ex_valid, 1);
      chk("sw_hold_memwr", ex_ctrl[3], 1);
      chk("sw_hold_ready", id_ready, 0);
    end
    step(0, 1, 6'h09, 0, 0, 4, 0, 0, 1); #1;
    chk("sw_advance_ready", id_ready, 1);
    idle(1); #1;
    chk("sw_next_wreg", ex_wreg, 4);
    chk("sw_no_timeout", mem_timeout, 0);
    chk("sw_stall_cnt", stall_cnt, 4);

    // lw with memory never ready: timeout
    step(0, 1, 6'h12, 0, 0, 9, 0, 0, 1);
    for (int i = 0; i < TO + 1; i++) begin
      idle(0); #1;
      chk("to_hold_valid", ex_valid, 1);
      chk("to_not_yet", mem_timeout, 0);
    end
    step(0, 1, 6'h09, 0, 0, 2, 0, 0, 0); #1;
    chk("to_flag", mem_timeout, 1);
    chk("to_cleared", ex_valid, 0);
    chk("to_run_issue", id_ready, 1);

    // beq taken: two slots discarded
    step(0, 1, 6'h05, 0, 1, 2, 0, 0, 1);
    step(0, 1, 6'h09, 0, 0, 10, 0, 1, 1); #1;
    chk("br_discard1", id_ready, 1);
    step(0, 1, 6'h09, 0, 0, 11, 0, 0, 1); #1;
    chk("br_bubble1", ex_valid, 0);
    chk("br_discard2", id_ready, 1);
    step(0, 1, 6'h09, 0, 0, 12, 0, 0, 1); #1;
    chk("br_bubble2", ex_valid, 0);
    step(0, 1, 6'h09, 0, 0, 13, 0, 1, 1); #1;
    chk("br_resume_wreg", ex_wreg, 12);
    chk("br_ignored_ready", id_ready, 1);
    idle(1); #1;
    chk("br_ignored_wreg", ex_wreg, 13);

    // illegal opcode, then reset during a memory wait
    step(0, 1, 6'h3f, 0, 0, 0, 0, 0, 1); #1;
    chk("ill_consumed", id_ready, 1);
    idle(1); #1;
    chk("ill_pulse", illegal, 1);
    chk("ill_bubble", ex_valid, 0);
    idle(1); #1;
    chk("ill_pulse_end", illegal, 0);
    step(0, 1, 6'h12, 0, 0, 1, 0, 0, 1);
    idle(0);
    idle(0);
    step(1, 1, 6'h09, 0, 0, 1, 0, 0, 0); #1;
    chk("arst_ex_valid", ex_valid, 0);
    chk("arst_ex_ctrl", ex_ctrl, 0);
    chk("arst_ex_wreg", ex_wreg, 0);
    chk("arst_illegal", illegal, 0);
    chk("arst_timeout", mem_timeout, 0);
    chk("arst_stall", stall_cnt, 0);
    chk("arst_ready", id_ready, 0);

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 4) != 0),
           ops[$urandom_range(0, 15)], fns[$urandom_range(0, 3)],
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) != 0));
    end
    idle(1);
    @(negedge clk); #1;
    chk("queues_drained", st_q.size() + ex_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_control_unit.md
PIPE_CONTROL_UNIT -- requirements
Module: pipe_control_unit

Interface
REQ-001 The block SHALL have one clock and asynchronous active-high reset: clk (rising edge), rst.
REQ-002 The block SHALL have these parameters:
- ALUOP_W, default 3: ALU op field width.
- REG_AW, default 5: register address width.
- TIMEOUT, default 16: maximum memory-wait cycles.
- CNT_W, default 8: stall counter width.
REQ-003 The block SHALL have these ports:
- clk  in  1  clock
- rst  in  1  async active-high reset
- id_valid  in  1  instruction present at decode
- opcode  in  6  instruction opcode
- func  in  6  R-type function code
- rs  in  REG_AW  source register address
- rt  in  REG_AW  target register address
- rd  in  REG_AW  destination register address
- branch_taken  in  1  EX resolved a taken branch or jump
- mem_ready  in  1  data memory completes the access held in EX
- id_ready  out  1  decode slot consumed this cycle
- ex_valid  out  1  EX register holds a live instruction
- ex_ctrl  out  16+ALUOP_W  packed registered controls
- ex_wreg  out  REG_AW  resolved destination register
- illegal  out  1  one-cycle pulse for an undefined opcode or func
- mem_timeout  out  1  sticky memory timeout flag
- stall_cnt  out  CNT_W  saturating stall-cycle count

Function
REQ-004 ex_ctrl packing SHALL be, MSB to LSB: aluop[ALUOP_W], regwrite, regdest[2], alusrc1, alusrc2[2], jump[2], branch[2], regsrc[2], mem_wr, mem_rd, word_byte, zero_ext.
REQ-005 Decode defaults SHALL be all fields 0, except alusrc1=1.
REQ-006 Opcode 0x03 with func 0x08 (jr) SHALL decode to jump=10.
REQ-007 Opcode 0x03 with func 0x21 (lwn) SHALL decode to regwrite=1, regdest=00, mem_rd=1, regsrc=01.
REQ-008 Opcode 0x03 with func 0x13 (swn) SHALL decode to mem_wr=1.
REQ-009 Opcode 0x03 with any other func SHALL decode to regwrite=1, regdest=01, aluop=0.
REQ-010 Opcode 0x02 (j) SHALL decode to jump=01.
REQ-011 Opcode 0x07 (jal) SHALL decode to regwrite=1, jump=01, regdest=10, alusrc1=0, alusrc2=10, aluop=1.
REQ-012 Opcode 0x09 (addi) SHALL decode to aluop=1, regwrite=1, alusrc2=01.
REQ-013 Opcode 0x0c (andi) SHALL decode as addi but with aluop=3 and zero_ext=1; opcode 0x0e (ori) as addi but with aluop=4 and zero_ext=1.
REQ-014 Opcodes 0x05 (beq) and 0x04 (bne) SHALL decode to aluop=2 with branch=01 and branch=10 respectively.
REQ-015 Opcodes 0x12 (lw) and 0x22 (lbu) SHALL decode to aluop=1, alusrc2=01, regwrite=1, mem_rd=1, regsrc=01, with word_byte=0 and word_byte=1 respectively.
REQ-016 Opcodes 0x2b (sw) and 0x28 (sb) SHALL decode to aluop=1, alusrc2=01, mem_wr=1, with word_byte=0 and word_byte=1 respectively.
REQ-017 Opcode 0x0f (lui) SHALL decode to regwrite=1, regsrc=10.
REQ-018 Any other opcode SHALL be illegal.
REQ-019 ex_wreg SHALL be rt when regdest=00, rd when regdest=01, and all-ones when regdest=10; it is registered together with ex_ctrl.
REQ-020 FSM states SHALL be RUN, MEM_WAIT, FLUSH.
REQ-021 mem_hold SHALL be defined as ex_valid & (mem_rd|mem_wr) & !mem_ready; while mem_hold is high the EX register holds, id_ready=0, and the state goes to MEM_WAIT.
REQ-022 In MEM_WAIT, a wait counter SHALL increment each cycle; on mem_ready the EX register advances and the state returns to RUN.
REQ-023 When the wait counter reaches TIMEOUT, the block SHALL set mem_timeout=1 (held until rst), clear ex_valid, and return to RUN.
REQ-024 branch_taken SHALL be honoured only when ex_valid=1 and ex jump!=00 or branch!=00; otherwise it is ignored.
REQ-025 A honoured branch_taken SHALL cause the next edge to load a bubble (ex_valid=0), consume and discard the decode slot (id_ready=1), and enter FLUSH.
REQ-026 FLUSH SHALL last one cycle, consuming and discarding id_valid, then return to RUN.
REQ-027 Load-use hazard SHALL be defined as ex_valid & mem_rd & ex_wreg!=0 & (ex_wreg==rs | ex_wreg==rt).
REQ-028 On a load-use hazard, id_ready SHALL be 0 and a bubble SHALL be loaded; the instruction is accepted on the following cycle.
REQ-029 Priority SHALL be rst > mem_hold > branch flush > load-use > normal issue.
REQ-030 Normal issue SHALL apply when id_valid=1 in RUN: id_ready=1, and the next edge loads the decoded ex_ctrl and ex_wreg with ex_valid=1.
REQ-031 When id_valid=0 in RUN, the next edge SHALL load ex_valid=0.
REQ-032 An illegal instruction SHALL be consumed, load a bubble, and produce an illegal pulse on the next cycle.
REQ-033 Latency SHALL be one cycle from decode to EX register.
REQ-034 stall_cnt SHALL increment each cycle with id_valid=1 and id_ready=0, and saturate at all-ones.

Reset
REQ-035 On rst assertion, ex_valid, ex_ctrl (including alusrc1), ex_wreg, illegal, mem_timeout, stall_cnt and the wait counter SHALL clear to 0, and the state SHALL go to RUN, immediately and regardless of any operation in progress.
REQ-036 id_ready SHALL be 0 while rst is high.

Verification
REQ-037 The bench SHALL cover: addi (0x09), rt=3, one cycle -> next cycle ex_valid=1, aluop=1, regwrite=1, alusrc2=01, ex_wreg=3.
REQ-038 The bench SHALL cover: lw to r5, then add with rs=5 -> id_ready=0 for one cycle, one bubble, add issued the following cycle, stall_cnt=1.
REQ-039 The bench SHALL cover: sw in EX with mem_ready=0 for 3 cycles -> EX held 3 cycles, then advance; mem_timeout=0.
REQ-040 The bench SHALL cover: TIMEOUT=4, mem_ready held low -> after 4 wait cycles mem_timeout=1, ex_valid=0, state RUN.
REQ-041 The bench SHALL cover: beq in EX with branch_taken=1 -> the next two decode slots are discarded, ex_valid=0 for two cycles.
REQ-042 The bench SHALL cover: opcode 0x3f -> illegal pulses for one cycle, ex_valid=0; then rst asserted mid-MEM_WAIT -> all outputs 0 asynchronously.
